core_seq: RTL and testbench

- Tile sequencer that drives the 34-bit instruction bus and the mode strobes of the PE core for one weight-stationary tile.
- Sequence for one tile:
  - load `row` weight vectors from weight SRAM into L0, then into the PE array;
  - stream `x_len` activation vectors through L0 and execute;
  - drain `x_len` OFIFO results into psum SRAM.
- Sits between the testbench/host start interface and the core; one tile per start pulse.

---
 rtl/core_seq_if.sv | 31 +++
 rtl/core_seq.sv | 202 ++++++++++++++++++++
 tb/tb_core_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_if.sv
// Host/core-facing bundle of the tile sequencer: start and tile descriptor
// from the host, OFIFO status from the core, instruction bus and mode strobes
// back to the core.
interface core_seq_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] p_base;
    logic [ADDR_W-1:0] x_len;
    logic              ofifo_valid;
    logic [33:0]       inst;
    logic              xw_mode;
    logic              pmem_mode;
    logic              sfp_reset;
    logic              busy;
    logic              done;

    // Host / core side: issues tiles, consumes the instruction stream.
    modport master (
        output start, w_base, x_base, p_base, x_len, ofifo_valid,
        input  inst, xw_mode, pmem_mode, sfp_reset, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, w_base, x_base, p_base, x_len, ofifo_valid,
        output inst, xw_mode, pmem_mode, sfp_reset, busy, done
    );
endinterface

// File: rtl/core_seq.sv
// Weight-stationary tile sequencer: loads `row` weight vectors into L0 and the
// PE array, flushes, streams x_len activations through L0 with execute, then
// drains x_len OFIFO rows into psum SRAM. One tile per start pulse.
// Instruction layout is fixed at 34 bits with 11-bit SRAM addresses.
module core_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int ADDR_W = 11,
    parameter int FLUSH  = 16
) (
    input logic     clk,
    input logic     reset,
    core_seq_if.slave bus
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ROW_LAST = CW'(row - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
    localparam logic [CW-1:0] FL_LAST  = CW'(FLUSH - 1);

    // Strobe field [6:0]: ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load
    localparam logic [6:0] S_NONE     = 7'b000_0000;
    localparam logic [6:0] S_OFIFO_RD = 7'b100_0000;
    localparam logic [6:0] S_L0_RD    = 7'b000_1000;
    localparam logic [6:0] S_L0_WR    = 7'b000_0100;
    localparam logic [6:0] S_EXECUTE  = 7'b000_0010;
    localparam logic [6:0] S_LOAD     = 7'b000_0001;

    typedef enum logic [2:0] {
        IDLE, W_RD, W_LD, W_FL, X_RD, EXEC, DRAIN, DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     wr_cnt;
    logic [ADDR_W-1:0] w_base_q;
    logic [ADDR_W-1:0] x_base_q;
    logic [ADDR_W-1:0] p_base_q;
    logic [ADDR_W-1:0] len_q;
    logic [CW-1:0]     len_full;
    logic [CW-1:0]     len_last;
    logic              rd_issue;

    logic [33:0]       inst_q;
    logic              xw_mode_q;
    logic              pmem_mode_q;
    logic              sfp_reset_q;
    logic              busy_q;
    logic              done_q;

    // Both memories disabled, only the given strobes active.
    function automatic logic [33:0] idle_inst(input logic [6:0] strb);
        return {1'b0, 1'b1, 1'b1, {ADDR_W{1'b0}}, 1'b1, 1'b1, {ADDR_W{1'b0}}, strb};
    endfunction

    // Activation/weight SRAM read at address a.
    function automatic logic [33:0] xrd_inst(input logic [ADDR_W-1:0] a, input logic [6:0] strb);
        return {1'b0, 1'b1, 1'b1, {ADDR_W{1'b0}}, 1'b0, 1'b1, a, strb};
    endfunction

    // Psum SRAM write at address a.
    function automatic logic [33:0] pwr_inst(input logic [ADDR_W-1:0] a, input logic [6:0] strb);
        return {1'b0, 1'b0, 1'b0, a, 1'b1, 1'b1, {ADDR_W{1'b0}}, strb};
    endfunction

    // Tile length helpers and OFIFO read issue decision.
    always_comb begin
        len_full = {1'b0, len_q};
        len_last = len_full - CW'(1);
        rd_issue = bus.ofifo_valid && (rd_cnt != len_full);
    end

    // Sequencer FSM; every output is registered and describes the cycle being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            w_base_q    <= '0;
            x_base_q    <= '0;
            p_base_q    <= '0;
            len_q       <= '0;
            inst_q      <= idle_inst(S_NONE);
            xw_mode_q   <= 1'b0;
            pmem_mode_q <= 1'b0;
            sfp_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sfp_reset_q <= 1'b0;
            done_q      <= 1'b0;
            pmem_mode_q <= 1'b0;
            case (state)
                IDLE: begin
                    inst_q <= idle_inst(S_NONE);
                    if (bus.start) begin
                        w_base_q    <= bus.w_base;
                        x_base_q    <= bus.x_base;
                        p_base_q    <= bus.p_base;
                        len_q       <= (bus.x_len == '0) ? ADDR_W'(1) : bus.x_len;
                        cnt         <= '0;
                        state       <= W_RD;
                        inst_q      <= xrd_inst(bus.w_base, S_NONE);
                        sfp_reset_q <= 1'b1;
                        xw_mode_q   <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                // l0_wr trails each read by one cycle, so the final write lands in W_LD.
                W_RD: begin
                    if (cnt == ROW_LAST) begin
                        cnt    <= '0;
                        state  <= W_LD;
                        inst_q <= idle_inst(S_L0_RD | S_LOAD | S_L0_WR);
                    end else begin
                        cnt    <= cnt + CW'(1);
                        inst_q <= xrd_inst(w_base_q + ADDR_W'(cnt + CW'(1)), S_L0_WR);
                    end
                end
                W_LD: begin
                    if (cnt == COL_LAST) begin
                        cnt    <= '0;
                        state  <= W_FL;
                        inst_q <= idle_inst(S_NONE);
                    end else begin
                        cnt    <= cnt + CW'(1);
                        inst_q <= idle_inst(S_L0_RD | S_LOAD);
                    end
                end
                W_FL: begin
                    if (cnt == FL_LAST) begin
                        cnt       <= '0;
                        state     <= X_RD;
                        xw_mode_q <= 1'b0;
                        inst_q    <= xrd_inst(x_base_q, S_NONE);
                    end else begin
                        cnt    <= cnt + CW'(1);
                        inst_q <= idle_inst(S_NONE);
                    end
                end
                X_RD: begin
                    if (cnt == len_last) begin
                        cnt    <= '0;
                        state  <= EXEC;
                        inst_q <= idle_inst(S_L0_RD | S_EXECUTE | S_L0_WR);
                    end else begin
                        cnt    <= cnt + CW'(1);
                        inst_q <= xrd_inst(x_base_q + ADDR_W'(cnt + CW'(1)), S_L0_WR);
                    end
                end
                EXEC: begin
                    if (cnt == len_last) begin
                        cnt    <= '0;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        state  <= DRAIN;
                        inst_q <= idle_inst(S_NONE);
                    end else begin
                        cnt    <= cnt + CW'(1);
                        inst_q <= idle_inst(S_L0_RD | S_EXECUTE);
                    end
                end
                // An OFIFO read cycle is always followed by the matching pmem write cycle.
                DRAIN: begin
                    if (!inst_q[32] && wr_cnt == len_full) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        inst_q <= idle_inst(S_NONE);
                    end else begin
                        if (rd_issue) begin
                            rd_cnt <= rd_cnt + CW'(1);
                        end
                        if (inst_q[6]) begin
                            wr_cnt <= wr_cnt + CW'(1);
                            inst_q <= pwr_inst(p_base_q + ADDR_W'(wr_cnt),
                                               rd_issue ? S_OFIFO_RD : S_NONE);
                        end else begin
                            inst_q <= idle_inst(rd_issue ? S_OFIFO_RD : S_NONE);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    inst_q <= idle_inst(S_NONE);
                end
                default: begin
                    state  <= IDLE;
                    inst_q <= idle_inst(S_NONE);
                end
            endcase
        end
    end

    assign bus.inst      = inst_q;
    assign bus.xw_mode   = xw_mode_q;
    assign bus.pmem_mode = pmem_mode_q;
    assign bus.sfp_reset = sfp_reset_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: a negedge monitor logs memory traffic and
// strobe protocol per tile; the main process runs tiles and compares the log
// against hand-computed address sequences and counts.
module tb_core_seq;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    core_seq_if #(.ADDR_W(11)) bus ();

    core_seq #(.row(8), .col(8), .ADDR_W(11), .FLUSH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor state
    logic        arm;
    int          vmode;
    int          vcnt;
    int          cyc;
    logic        prev_read;
    logic        prev_ordy;
    logic [10:0] rd_addr[$];
    logic        rd_xw[$];
    logic [10:0] wr_addr[$];
    int          l0wr_n, l0wr_bad, load_n, exec_n, both_bad, wr_bad;
    int          ordy_n, done_n, sfp_n, fixed_bad, last_load_cyc, first_x_cyc;

    // Logs one cycle of DUT output; also drives ofifo_valid for the next edge.
    always @(negedge clk) begin
        if (arm) begin
            rd_addr.delete(); rd_xw.delete(); wr_addr.delete();
            l0wr_n = 0; l0wr_bad = 0; load_n = 0; exec_n = 0; both_bad = 0;
            wr_bad = 0; ordy_n = 0; done_n = 0; sfp_n = 0; fixed_bad = 0;
            last_load_cyc = -1; first_x_cyc = -1; cyc = 0; vcnt = 0;
            prev_read = 1'b0; prev_ordy = 1'b0;
        end else begin
            if (!bus.inst[19]) begin
                rd_addr.push_back(bus.inst[17:7]);
                rd_xw.push_back(bus.xw_mode);
                if (!bus.xw_mode && first_x_cyc < 0) first_x_cyc = cyc;
                if (bus.inst[18] !== 1'b1) fixed_bad++;
            end
            if (bus.inst[2]) l0wr_n++;
            if (bus.inst[2] !== prev_read) l0wr_bad++;
            if (bus.inst[0]) begin load_n++; last_load_cyc = cyc; end
            if (bus.inst[1]) exec_n++;
            if (bus.inst[0] && bus.inst[1]) both_bad++;
            if (!bus.inst[32]) begin
                wr_addr.push_back(bus.inst[30:20]);
                if (bus.inst[31] !== 1'b0 || !prev_ordy) wr_bad++;
            end
            if (bus.inst[6]) ordy_n++;
            if (bus.done) done_n++;
            if (bus.sfp_reset) sfp_n++;
            if (bus.inst[33] || bus.inst[5] || bus.inst[4] || bus.pmem_mode) fixed_bad++;
            prev_read = !bus.inst[19];
            prev_ordy = bus.inst[6];
            cyc++;
            vcnt++;
        end
        bus.ofifo_valid = (vmode == 0) ? 1'b1 : ((vcnt % 3) == 0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_tile(input logic [10:0] wb, input logic [10:0] xb,
                              input logic [10:0] pb, input logic [10:0] len);
        bus.w_base = wb; bus.x_base = xb; bus.p_base = pb; bus.x_len = len;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1'b1);
        check("sfp_reset_pulse", bus.sfp_reset, 1'b1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_n == 0 && t < 3000) begin tick(); t++; end
        check("done_seen", (done_n != 0), 1'b1);
        repeat (3) tick();
    endtask

    // exp_x holds the expected activation addresses (len entries).
    task automatic verify_tile(input string nm, input logic [10:0] wb, input logic [10:0] pb,
                               input int len, input logic [10:0] exp_x[4]);
        logic [10:0] a;
        check({nm, "_rd_count"}, rd_addr.size(), 8 + len);
        for (int i = 0; i < 8 + len && i < rd_addr.size(); i++) begin
            if (i < 8) begin
                a = wb + 11'(i);
                check({nm, "_w_addr"}, rd_addr[i], a);
                check({nm, "_w_xw"}, rd_xw[i], 1'b1);
            end else begin
                check({nm, "_x_addr"}, rd_addr[i], exp_x[i - 8]);
                check({nm, "_x_xw"}, rd_xw[i], 1'b0);
            end
        end
        check({nm, "_l0wr_count"}, l0wr_n, 8 + len);
        check({nm, "_l0wr_lag"}, l0wr_bad, 0);
        check({nm, "_load_count"}, load_n, 8);
        check({nm, "_exec_count"}, exec_n, len);
        check({nm, "_load_exec_excl"}, both_bad, 0);
        check({nm, "_flush_gap"}, first_x_cyc - last_load_cyc - 1, 16);
        check({nm, "_wr_count"}, wr_addr.size(), len);
        for (int i = 0; i < len && i < wr_addr.size(); i++) begin
            a = pb + 11'(i);
            check({nm, "_p_addr"}, wr_addr[i], a);
        end
        check({nm, "_wr_after_rd"}, wr_bad, 0);
        check({nm, "_ofifo_rd_count"}, ordy_n, len);
        check({nm, "_done_count"}, done_n, 1);
        check({nm, "_sfp_count"}, sfp_n, 1);
        check({nm, "_fixed_fields"}, fixed_bad, 0);
        check({nm, "_idle_busy"}, bus.busy, 1'b0);
        check({nm, "_idle_inst"}, bus.inst, IDLE_INST);
    endtask

    initial begin
        logic [10:0] xs[4];
        int t;
        n_checks = 0; n_errors = 0;
        arm = 1'b1; vmode = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.w_base = '0; bus.x_base = '0; bus.p_base = '0; bus.x_len = '0;
        repeat (3) tick();
        reset = 1'b0;
        arm = 1'b0;
        repeat (5) tick();
        check("reset_inst", bus.inst, IDLE_INST);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_xw", bus.xw_mode, 1'b0);
        check("reset_pmem_mode", bus.pmem_mode, 1'b0);
        check("reset_sfp", bus.sfp_reset, 1'b0);

        // Basic tile, OFIFO always ready.
        xs = '{11'h100, 11'h101, 11'h102, 11'h103};
        vmode = 0;
        begin_tile(11'h010, 11'h100, 11'h020, 11'd4);
        wait_done();
        verify_tile("basic", 11'h010, 11'h020, 4, xs);

        // Same tile with OFIFO bubbles.
        vmode = 1;
        begin_tile(11'h010, 11'h100, 11'h020, 11'd4);
        wait_done();
        verify_tile("bubble", 11'h010, 11'h020, 4, xs);
        vmode = 0;

        // Activation address wrap.
        xs = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        begin_tile(11'h010, 11'h7FE, 11'h020, 11'd4);
        wait_done();
        verify_tile("wrap", 11'h010, 11'h020, 4, xs);

        // Reset in the middle of EXEC, then a clean tile.
        xs = '{11'h100, 11'h101, 11'h102, 11'h103};
        begin_tile(11'h010, 11'h100, 11'h020, 11'd4);
        t = 0;
        while (exec_n < 2 && t < 200) begin tick(); t++; end
        check("reach_exec", (exec_n >= 2), 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_inst", bus.inst, IDLE_INST);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_xw", bus.xw_mode, 1'b0);
        check("abort_done", bus.done, 1'b0);
        tick();
        begin_tile(11'h010, 11'h100, 11'h020, 11'd4);
        wait_done();
        verify_tile("post_reset", 11'h010, 11'h020, 4, xs);

        // start pulsed during DRAIN must be ignored.
        vmode = 1;
        begin_tile(11'h010, 11'h100, 11'h020, 11'd4);
        t = 0;
        while (exec_n < 4 && t < 200) begin tick(); t++; end
        check("reach_drain", (exec_n == 4), 1'b1);
        repeat (2) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done();
        repeat (60) tick();
        verify_tile("drain_start", 11'h010, 11'h020, 4, xs);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
